multicycle_control: RTL and testbench

Multi-cycle sequencer for the 32-bit MIPS datapath. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath mux selects and write enables. It waits on a memory ready handshake for every instruction or data access. It sits between the instruction register (opcode source), the shared instruction/data memory and the register file/ALU/PC datapath.

---
 rtl/multicycle_control_if.sv | 37 +++
 rtl/multicycle_control.sv | 179 +++++++++++++++++
 tb/tb_multicycle_control.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle sequencer (master) and the MIPS datapath/memory (slave).
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       jal;
  logic       instr_done;
  logic       illegal_op;
  logic       mem_timeout;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
           jal, instr_done, illegal_op, mem_timeout, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
           jal, instr_done, illegal_op, mem_timeout, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: fetch/decode/execute/memory/writeback FSM with
// memory-ready handshake and a bounded wait counter that aborts stalled accesses.
module multicycle_control #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  RTEXEC = 4'd6,  RTWB   = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  JAL    = 4'd10, ITEXEC = 4'd11,
    ITWB   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [3:0] WAIT_LIMIT = 4'(MEM_WAIT_MAX);

  state_e     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       waiting;
  logic       timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.i_or_d       = 1'b0;
    bus.ir_write     = 1'b0;
    bus.pc_write     = 1'b0;
    bus.pc_source    = 2'b00;
    bus.alu_src_a    = 1'b0;
    bus.alu_src_b    = 2'b00;
    bus.alu_op       = 2'b00;
    bus.reg_write    = 1'b0;
    bus.reg_dst      = 1'b0;
    bus.mem_to_reg   = 1'b0;
    bus.jal          = 1'b0;
    bus.instr_done   = 1'b0;
    bus.illegal_op   = 1'b0;
    bus.mem_timeout  = 1'b0;
    bus.state        = reset ? 4'd0 : state_q;
    waiting = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    timeout = waiting && !bus.mem_ready && (wait_cnt_q == WAIT_LIMIT);

    if (!reset) begin
      case (state_q)
        FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_d      = DECODE;
          end
        end
        DECODE: begin
          bus.alu_src_b = 2'b11;
          case (bus.opcode)
            OP_RTYPE:      state_d = RTEXEC;
            OP_LW, OP_SW:  state_d = MEMADR;
            OP_BEQ, OP_BNE: state_d = BRANCH;
            OP_J:          state_d = JUMP;
            OP_JAL:        state_d = JAL;
            OP_ADDI:       state_d = ITEXEC;
            default: begin
              bus.illegal_op = 1'b1;
              bus.instr_done = 1'b1;
              state_d        = FETCH;
            end
          endcase
        end
        MEMADR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          state_d       = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
          if (bus.mem_ready) state_d = MEMWB;
        end
        MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          bus.instr_done = 1'b1;
          state_d        = FETCH;
        end
        MEMWR: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
          if (bus.mem_ready) begin
            bus.instr_done = 1'b1;
            state_d        = FETCH;
          end
        end
        RTEXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'b10;
          state_d       = RTWB;
        end
        RTWB: begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = 1'b1;
          bus.instr_done = 1'b1;
          state_d        = FETCH;
        end
        ITEXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          state_d       = ITWB;
        end
        ITWB: begin
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
          state_d        = FETCH;
        end
        BRANCH: begin
          bus.alu_src_a  = 1'b1;
          bus.alu_op     = 2'b01;
          bus.pc_source  = 2'b01;
          bus.instr_done = 1'b1;
          bus.pc_write   = ((bus.opcode == OP_BEQ) && bus.zero) ||
                           ((bus.opcode == OP_BNE) && !bus.zero);
          state_d        = FETCH;
        end
        JUMP: begin
          bus.pc_source  = 2'b10;
          bus.pc_write   = 1'b1;
          bus.instr_done = 1'b1;
          state_d        = FETCH;
        end
        JAL: begin
          bus.pc_source  = 2'b10;
          bus.pc_write   = 1'b1;
          bus.reg_write  = 1'b1;
          bus.jal        = 1'b1;
          bus.instr_done = 1'b1;
          state_d        = FETCH;
        end
        default: state_d = FETCH;
      endcase

      // An expired wait abandons the access: strobes drop and nothing is written.
      if (timeout) begin
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.instr_done  = 1'b0;
        bus.mem_timeout = 1'b1;
        state_d         = FETCH;
      end
    end

    wait_cnt_d = (waiting && !bus.mem_ready && !timeout && (state_d == state_q))
                 ? wait_cnt_q + 4'd1 : 4'd0;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction stream against a cycle-count/effect model of the sequencer,
// plus directed reset checks; a monitor scores each completed or aborted instruction.
module tb_multicycle_control;
  localparam int MAXW = 15;
  localparam int NTXN = 120;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if bus ();
  multicycle_control #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int op; int timeout; int cycles; int ir_w; int pc_w; int reg_w;
    int illegal; int jal; int m2r; int strobes; int pcsrc;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  int   fetch_delay = 0;
  int   data_delay  = 0;
  bit   mon_en = 1'b0;
  int   txn = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write, bus.pc_write,
                 bus.pc_source, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write,
                 bus.reg_dst, bus.mem_to_reg, bus.jal, bus.instr_done, bus.illegal_op,
                 bus.mem_timeout});
  endfunction

  // Effect of one instruction given how many cycles memory holds off each access.
  // pcsrc is a bitmask of pc_source values seen on PC loads.
  function automatic exp_t model(input int op, input bit z, input int fd, input int dd);
    exp_t e = '{default: 0};
    e.op = op;
    if (fd > MAXW) begin
      e.timeout = 1; e.cycles = MAXW + 1; e.strobes = MAXW;
      return e;
    end
    e.cycles = fd + 2; e.strobes = fd + 1; e.ir_w = 1; e.pc_w = 1; e.pcsrc = 1;
    case (op)
      6'h00, 6'h08: begin e.cycles += 2; e.reg_w = 1; end
      6'h23, 6'h2b: begin
        e.cycles += 1;
        if (dd > MAXW) begin
          e.timeout = 1; e.cycles += MAXW + 1; e.strobes += MAXW;
        end else begin
          e.cycles += dd + 1; e.strobes += dd + 1;
          if (op == 6'h23) begin e.cycles += 1; e.reg_w = 1; e.m2r = 1; end
        end
      end
      6'h04, 6'h05: begin
        e.cycles += 1;
        if ((op == 6'h04) == z) begin e.pc_w += 1; e.pcsrc |= 2; end
      end
      6'h02: begin e.cycles += 1; e.pc_w += 1; e.pcsrc |= 4; end
      6'h03: begin e.cycles += 1; e.pc_w += 1; e.pcsrc |= 4; e.reg_w = 1; e.jal = 1; end
      default: e.illegal = 1;
    endcase
    return e;
  endfunction

  function automatic int pick_delay();
    int r = $urandom_range(0, 9);
    if (r < 6) return $urandom_range(0, 2);
    if (r < 8) return $urandom_range(3, 6);
    return $urandom_range(14, 19);
  endfunction

  task automatic gen_instr();
    int ops[10] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h3f, 6'h11};
    int op = ops[$urandom_range(0, 9)];
    bit z  = 1'($urandom_range(0, 1));
    bus.opcode  = 6'(op);
    bus.zero    = z;
    fetch_delay = pick_delay();
    data_delay  = pick_delay();
    expq.push_back(model(op, z, fetch_delay, data_delay));
  endtask

  // Memory responder: ready after the planned number of stall cycles; random noise
  // on mem_ready outside the waiting states.
  int acc = 0;
  bit last_end = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      bus.mem_ready = 1'b0; acc = 0; last_end = 1'b0;
    end else if (bus.state == 4'd0 || bus.state == 4'd3 || bus.state == 4'd5) begin
      if (last_end) acc = 0;
      bus.mem_ready = (acc >= ((bus.state == 4'd0) ? fetch_delay : data_delay));
      acc++;
      #1;
      last_end = bus.mem_ready || bus.mem_timeout;
    end else begin
      acc = 0; last_end = 1'b0;
      bus.mem_ready = 1'($urandom_range(0, 1));
    end
  end

  int a_cyc = 0, a_ir = 0, a_pcw = 0, a_reg = 0, a_ill = 0, a_jal = 0, a_m2r = 0, a_str = 0, a_pcs = 0;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (mon_en && !reset) begin
      a_cyc++;
      a_ir  += int'(bus.ir_write);
      a_pcw += int'(bus.pc_write);
      if (bus.pc_write) a_pcs |= (1 << bus.pc_source);
      a_reg += int'(bus.reg_write);
      a_ill += int'(bus.illegal_op);
      a_jal += int'(bus.jal);
      a_m2r += int'(bus.mem_to_reg);
      a_str += int'(bus.mem_read | bus.mem_write);
      if (bus.instr_done || bus.mem_timeout) begin
        check("done_timeout_exclusive", int'(bus.instr_done && bus.mem_timeout), 0);
        if (expq.size() == 0) begin
          check("unexpected_end", 1, 0);
        end else begin
          e = expq.pop_front();
          check("timeout", int'(bus.mem_timeout), e.timeout);
          check("cycles", a_cyc, e.cycles);
          check("ir_write", a_ir, e.ir_w);
          check("pc_write", a_pcw, e.pc_w);
          check("pc_source", a_pcs, e.pcsrc);
          check("reg_write", a_reg, e.reg_w);
          check("illegal_op", a_ill, e.illegal);
          check("jal", a_jal, e.jal);
          check("mem_to_reg", a_m2r, e.m2r);
          check("strobe_cycles", a_str, e.strobes);
          $display("txn %0d op=%02h timeout=%0d cycles=%0d regw=%0d pcw=%0d errors=%0d",
                   txn, e.op, bus.mem_timeout, a_cyc, a_reg, a_pcw, errors);
        end
        txn++;
        a_cyc = 0; a_ir = 0; a_pcw = 0; a_reg = 0; a_ill = 0;
        a_jal = 0; a_m2r = 0; a_str = 0; a_pcs = 0;
      end
    end
  end

  bit rw_seen = 1'b0;
  always @(negedge clk) if (!mon_en && bus.reg_write) rw_seen = 1'b1;

  initial begin
    bit found;
    bit ended;
    reset = 1'b1;
    bus.opcode = 6'h23;
    bus.zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    check("reset_state", int'(bus.state), 0);
    check("reset_outputs", outs(), 0);

    @(posedge clk); #1;
    reset = 1'b0;
    fetch_delay = 0;
    data_delay = 40;
    @(negedge clk); #2;
    check("first_fetch_strobe", int'(bus.mem_read), 1);
    check("first_fetch_state", int'(bus.state), 0);

    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.state == 4'd3) begin found = 1'b1; break; end
      @(negedge clk); #2;
    end
    check("reach_memrd", int'(found), 1);
    check("memrd_i_or_d", int'(bus.i_or_d), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #2;
    check("reset_in_memrd_outputs", outs(), 0);
    @(posedge clk); #1;
    @(negedge clk); #2;
    check("reset_in_memrd_state", int'(bus.state), 0);
    check("reset_in_memrd_no_regwrite", int'(rw_seen), 0);

    @(posedge clk); #1;
    gen_instr();
    reset = 1'b0;
    mon_en = 1'b1;
    for (int n = 0; n < NTXN; n++) begin
      ended = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk); #2;
        if (bus.instr_done || bus.mem_timeout) begin ended = 1'b1; break; end
      end
      if (!ended) begin
        check("instr_end_within_budget", 0, 1);
        break;
      end
      @(posedge clk); #1;
      if (n < NTXN - 1) gen_instr();
      else mon_en = 1'b0;
    end
    mon_en = 1'b0;
    repeat (3) @(posedge clk);
    check("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
